// File: rtl/mem_arbiter_pkg.sv
// Shared defines for the IFU/LSU memory arbiter: bus-width macros, FSM
// state encodings and the IFU fetch byte-enable constant.
`ifndef MEM_ARBITER_DEFINES
`define MEM_ARBITER_DEFINES
`define RegBus   31:0
`define ZeroWord 32'h0000_0000
`endif

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    LS_WAIT = 2'd2
  } arb_state_e;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] IF_BE = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus (request/grant, response valid/data) seen from the
// arbiter (master) and from the memory (slave).
interface mem_arbiter_if;
  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [`RegBus] addr;
  logic [`RegBus] wdata;
  logic          gnt;
  logic          rvalid;
  logic [`RegBus] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IFU fetches and LSU accesses onto one memory port, one
// transaction outstanding. Define ARB_STARVE_GUARD_EN to bound IFU starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           if_req_i,
  input  logic [`RegBus] if_addr_i,
  output logic           if_gnt_o,
  output logic           if_rvalid_o,
  output logic [`RegBus] if_rdata_o,
  input  logic           ls_req_i,
  input  logic           ls_we_i,
  input  logic [3:0]     ls_be_i,
  input  logic [`RegBus] ls_addr_i,
  input  logic [`RegBus] ls_wdata_i,
  output logic           ls_gnt_o,
  output logic           ls_rvalid_o,
  output logic [`RegBus] ls_rdata_o,
  output logic           mem_req_o,
  output logic           mem_we_o,
  output logic [3:0]     mem_be_o,
  output logic [`RegBus] mem_addr_o,
  output logic [`RegBus] mem_wdata_o,
  input  logic           mem_gnt_i,
  input  logic           mem_rvalid_i,
  input  logic [`RegBus] mem_rdata_i,
  output logic           stallreq_from_if_o,
  output logic           stallreq_from_mem_o
);

  arb_state_e state_q, state_d;
  logic       drop_q, drop_d;
  logic       if_win, ls_win, starve_hit;

`ifdef ARB_STARVE_GUARD_EN
  localparam int               CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]    LIMIT_C = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = (starve_cnt_q == LIMIT_C);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || if_gnt_o) starve_cnt_d = '0;
    else if (ls_gnt_o && starve_cnt_q != LIMIT_C) starve_cnt_d = starve_cnt_q + CW'(1);
  end
`else
  assign starve_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;

    // A flushed fetch is never worth starting, so flush masks the IFU request.
    if_win = (state_q == IDLE) && if_req_i && !flush_i && (!ls_req_i || starve_hit);
    ls_win = (state_q == IDLE) && ls_req_i && !if_win;

    mem_req_o   = if_win || ls_win;
    mem_we_o    = ls_win ? ls_we_i : 1'b0;
    mem_be_o    = ls_win ? ls_be_i : (if_win ? IF_BE : 4'h0);
    mem_addr_o  = ls_win ? ls_addr_i : (if_win ? if_addr_i : `ZeroWord);
    mem_wdata_o = ls_win ? ls_wdata_i : `ZeroWord;
    if_gnt_o    = if_win && mem_gnt_i;
    ls_gnt_o    = ls_win && mem_gnt_i;

    unique case (state_q)
      IDLE: begin
        if (if_gnt_o) begin
          state_d = IF_WAIT;
          if (flush_i) drop_d = 1'b1;
        end else if (ls_gnt_o) begin
          state_d = LS_WAIT;
        end
      end
      IF_WAIT: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_rvalid_i) begin
          if_rvalid_o = !(drop_q || flush_i);
          drop_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      LS_WAIT: begin
        if (mem_rvalid_i) begin
          ls_rvalid_o = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if_rdata_o          = if_rvalid_o ? mem_rdata_i : `ZeroWord;
    ls_rdata_o          = ls_rvalid_o ? mem_rdata_i : `ZeroWord;
    stallreq_from_mem_o = ls_req_i && !ls_rvalid_o;
    stallreq_from_if_o  = if_req_i && !if_rvalid_o && !stallreq_from_mem_o;
  end

  // NOTE: state flops use non-blocking assignments; reset here is synchronous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      drop_q       <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected values are
// hand-computed, with the starvation case following ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        stallreq_from_if_o, stallreq_from_mem_o;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if mem_bus ();

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .if_req_i            (if_req_i),
    .if_addr_i           (if_addr_i),
    .if_gnt_o            (if_gnt_o),
    .if_rvalid_o         (if_rvalid_o),
    .if_rdata_o          (if_rdata_o),
    .ls_req_i            (ls_req_i),
    .ls_we_i             (ls_we_i),
    .ls_be_i             (ls_be_i),
    .ls_addr_i           (ls_addr_i),
    .ls_wdata_i          (ls_wdata_i),
    .ls_gnt_o            (ls_gnt_o),
    .ls_rvalid_o         (ls_rvalid_o),
    .ls_rdata_o          (ls_rdata_o),
    .mem_req_o           (mem_bus.req),
    .mem_we_o            (mem_bus.we),
    .mem_be_o            (mem_bus.be),
    .mem_addr_o          (mem_bus.addr),
    .mem_wdata_o         (mem_bus.wdata),
    .mem_gnt_i           (mem_bus.gnt),
    .mem_rvalid_i        (mem_bus.rvalid),
    .mem_rdata_i         (mem_bus.rdata),
    .stallreq_from_if_o  (stallreq_from_if_o),
    .stallreq_from_mem_o (stallreq_from_mem_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, leaving time to drive new inputs before sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    flush_i = 0; if_req_i = 0; if_addr_i = 0;
    ls_req_i = 0; ls_we_i = 0; ls_be_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
    mem_bus.gnt = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, {31'd0, mem_bus.req}, 32'd0);
    check({tag, "_mem_addr"}, mem_bus.addr, 32'd0);
    check({tag, "_mem_be"}, {28'd0, mem_bus.be}, 32'd0);
    check({tag, "_gnts"}, {30'd0, if_gnt_o, ls_gnt_o}, 32'd0);
    check({tag, "_rvalids"}, {30'd0, if_rvalid_o, ls_rvalid_o}, 32'd0);
    check({tag, "_rdata"}, if_rdata_o | ls_rdata_o, 32'd0);
    check({tag, "_stalls"}, {30'd0, stallreq_from_if_o, stallreq_from_mem_o}, 32'd0);
  endtask

  initial begin
    logic [1:0] exp_gnt;

    // Reset state
    clear_inputs();
    rst_i = 1;
    step();
    step();
    check_all_zero("reset");
    rst_i = 0;

    // IFU-only fetch: grant cycle 0, response cycle 2
    if_req_i = 1; if_addr_i = 32'h100; mem_bus.gnt = 1;
    #1;
    check("f_req",   {31'd0, mem_bus.req}, 32'd1);
    check("f_addr",  mem_bus.addr, 32'h100);
    check("f_be_we", {27'd0, mem_bus.we, mem_bus.be}, 32'h0F);
    check("f_gnt",   {31'd0, if_gnt_o}, 32'd1);
    check("f_stall0", {31'd0, stallreq_from_if_o}, 32'd1);
    step();
    mem_bus.gnt = 0;
    #1;
    check("f_wait_req", {31'd0, mem_bus.req}, 32'd0);
    check("f_stall1",   {31'd0, stallreq_from_if_o}, 32'd1);
    check("f_rvalid1",  {31'd0, if_rvalid_o}, 32'd0);
    step();
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h0000_0013;
    #1;
    check("f_rvalid2", {31'd0, if_rvalid_o}, 32'd1);
    check("f_rdata2",  if_rdata_o, 32'h0000_0013);
    check("f_stall2",  {31'd0, stallreq_from_if_o}, 32'd0);
    step();
    clear_inputs();
    #1;
    check("f_idle_rvalid", {31'd0, if_rvalid_o}, 32'd0);

    // Simultaneous requests: LSU store first, IFU after ls_rvalid_o
    if_req_i = 1; if_addr_i = 32'h104;
    ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'b0011; ls_addr_i = 32'h2000; ls_wdata_i = 32'hDEAD_BEEF;
    mem_bus.gnt = 1;
    #1;
    check("c_gnts",   {30'd0, if_gnt_o, ls_gnt_o}, 32'b01);
    check("c_be",     {28'd0, mem_bus.be}, 32'b0011);
    check("c_we",     {31'd0, mem_bus.we}, 32'd1);
    check("c_addr",   mem_bus.addr, 32'h2000);
    check("c_wdata",  mem_bus.wdata, 32'hDEAD_BEEF);
    check("c_stalls", {30'd0, stallreq_from_if_o, stallreq_from_mem_o}, 32'b01);
    step();
    mem_bus.gnt = 0;
    #1;
    check("c_wait_req", {31'd0, mem_bus.req}, 32'd0);
    step();
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h55;
    #1;
    check("c_ls_rvalid", {31'd0, ls_rvalid_o}, 32'd1);
    check("c_ls_rdata",  ls_rdata_o, 32'h55);
    check("c_if_gnt_in_wait", {31'd0, if_gnt_o}, 32'd0);
    check("c_stalls2", {30'd0, stallreq_from_if_o, stallreq_from_mem_o}, 32'b10);
    step();
    ls_req_i = 0; mem_bus.rvalid = 0; mem_bus.gnt = 1;
    #1;
    check("c_if_gnt",  {31'd0, if_gnt_o}, 32'd1);
    check("c_if_addr", mem_bus.addr, 32'h104);
    check("c_if_bewe", {27'd0, mem_bus.we, mem_bus.be}, 32'h0F);
    step();
    mem_bus.gnt = 0; mem_bus.rvalid = 1; mem_bus.rdata = 32'h77;
    #1;
    check("c_if_rdata", if_rdata_o, 32'h77);
    check("c_ls_rdata_zero", ls_rdata_o, 32'd0);
    step();
    clear_inputs();

    // Flush in IF_WAIT drops the response; next fetch is normal
    if_req_i = 1; if_addr_i = 32'h40; mem_bus.gnt = 1;
    #1;
    check("x_gnt", {31'd0, if_gnt_o}, 32'd1);
    step();
    if_req_i = 0; mem_bus.gnt = 0; flush_i = 1;
    #1;
    step();
    flush_i = 0; mem_bus.rvalid = 1; mem_bus.rdata = 32'hBAD;
    #1;
    check("x_dropped", {31'd0, if_rvalid_o}, 32'd0);
    check("x_rdata0",  if_rdata_o, 32'd0);
    step();
    mem_bus.rvalid = 0; if_req_i = 1; if_addr_i = 32'h80; mem_bus.gnt = 1;
    #1;
    check("x_next_gnt",  {31'd0, if_gnt_o}, 32'd1);
    check("x_next_addr", mem_bus.addr, 32'h80);
    step();
    mem_bus.gnt = 0; mem_bus.rvalid = 1; mem_bus.rdata = 32'h1234;
    #1;
    check("x_next_rvalid", {31'd0, if_rvalid_o}, 32'd1);
    check("x_next_rdata",  if_rdata_o, 32'h1234);
    step();
    mem_bus.rvalid = 0; flush_i = 1; mem_bus.gnt = 1;
    #1;
    check("x_flush_mask", {30'd0, mem_bus.req, if_gnt_o}, 32'd0);
    step();
    clear_inputs();
    step();

    // Continuous requests on both ports
    if_req_i = 1; if_addr_i = 32'h200; ls_req_i = 1; ls_addr_i = 32'h3000; ls_be_i = 4'hF;
    mem_bus.gnt = 1;
    for (int k = 0; k < 10; k++) begin
      mem_bus.rvalid = 0;
      #1;
`ifdef ARB_STARVE_GUARD_EN
      exp_gnt = (k % 5 == 4) ? 2'b10 : 2'b01;
`else
      exp_gnt = 2'b01;
`endif
      check($sformatf("s_grant%0d", k), {30'd0, if_gnt_o, ls_gnt_o}, {30'd0, exp_gnt});
      step();
      mem_bus.rvalid = 1;
      #1;
      step();
    end
    clear_inputs();
    step();

    // Reset in LS_WAIT, then a stray response
    ls_req_i = 1; ls_addr_i = 32'h3004; ls_be_i = 4'hF; mem_bus.gnt = 1;
    #1;
    check("r_ls_gnt", {31'd0, ls_gnt_o}, 32'd1);
    step();
    mem_bus.gnt = 0; rst_i = 1;
    step();
    rst_i = 0; ls_req_i = 0;
    #1;
    check_all_zero("r_after");
    step();
    mem_bus.rvalid = 1; mem_bus.rdata = 32'hCAFE; if_req_i = 1; if_addr_i = 32'h300;
    #1;
    check("r_stray_rvalid", {30'd0, if_rvalid_o, ls_rvalid_o}, 32'd0);
    check("r_stray_rdata",  ls_rdata_o | if_rdata_o, 32'd0);
    check("r_idle_req",     {31'd0, mem_bus.req}, 32'd1);
    check("r_idle_addr",    mem_bus.addr, 32'h300);
    check("r_stalls_if",    {30'd0, stallreq_from_if_o, stallreq_from_mem_o}, 32'b10);
    step();
    mem_bus.rvalid = 0; if_req_i = 0; ls_req_i = 1;
    #1;
    check("r_stalls_ls", {30'd0, stallreq_from_if_o, stallreq_from_mem_o}, 32'b01);
    check("r_ls_win",    mem_bus.addr, 32'h3004);
    step();
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
